// File: rtl/video_pattern_checker_if.sv
// Pixel stream between a pattern source and the checker.
//   video      : {R,G,B} pixel, must be valid whenever VideoReady is high
//   VideoReady : consume strobe from the checker, one pixel per high cycle
// master = pattern source, slave = checker.
interface video_pattern_checker_if;
  logic [23:0] video;
  logic        VideoReady;

  modport master (output video, input  VideoReady);
  modport slave  (input  video, output VideoReady);
endinterface

// File: rtl/video_pattern_checker.sv
// Checks a two-colour vertical band test pattern against a free-running
// raster. The checker owns the raster timing and pulls pixels from the
// source with VideoReady during the active area only.
//
// Ports:
//   Clock, Reset     : single rising-edge clock, synchronous active-high reset
//   Enable           : level request to run; dropping it lets the frame finish
//   vid (slave)      : video pixel in, VideoReady strobe out
//   FrameDone        : pulse on the last cycle of every frame
//   FrameCount       : completed frames, wraps
//   ErrorCount       : mismatched pixels, saturating
//   Error            : sticky mismatch flag
//   FirstErrRow/Col/Pixel : raster position and pixel of the first mismatch
//
// Optional feature: define CHECKER_FIRST_ERROR_LOG_EN to build the
// first-error capture registers; otherwise FirstErr* are tied to 0.
module video_pattern_checker #(
  parameter int H_ACTIVE = 800,
  parameter int H_TOTAL  = 1056,
  parameter int V_ACTIVE = 600,
  parameter int V_TOTAL  = 628,
  parameter int BAND     = 80
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Enable,
  video_pattern_checker_if.slave   vid,
  output logic                     FrameDone,
  output logic [7:0]               FrameCount,
  output logic [15:0]              ErrorCount,
  output logic                     Error,
  output logic [9:0]               FirstErrRow,
  output logic [9:0]               FirstErrCol,
  output logic [23:0]              FirstErrPixel
);

  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int BW = (BAND > 1)    ? $clog2(BAND)    : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [BW-1:0] BAND_LAST = BW'(BAND - 1);
  localparam logic [HW:0]   H_ACT     = (HW+1)'(H_ACTIVE);
  localparam logic [VW:0]   V_ACT     = (VW+1)'(V_ACTIVE);

  localparam logic [23:0] TURQUOISE = 24'h1ABC9C;  // {26,188,156}
  localparam logic [23:0] CARROT    = 24'hE67E22;  // {230,126,34}

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic [BW-1:0]   band_cnt;
  logic            colour;
  logic            active;
  logic            last_cyc;
  logic            rdy;
  logic [23:0]     expected;
  logic            mismatch;

  // Everything here is decoded from registers only, so VideoReady has no
  // combinational path from Enable or video.
  assign active    = (state != IDLE);
  assign last_cyc  = active && (h == H_LAST) && (v == V_LAST);
  assign rdy       = active && ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
  assign vid.VideoReady = rdy;
  assign FrameDone = last_cyc;

  assign expected  = colour ? CARROT : TURQUOISE;
  assign mismatch  = rdy && (vid.video != expected);

  // FSM: STOP keeps the raster running so the current frame ends intact,
  // and can fall back to RUN without touching h/v.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable) state_nxt = RUN;
      RUN:     if (!Enable) state_nxt = STOP;
      STOP: begin
        if (last_cyc)    state_nxt = IDLE;
        else if (Enable) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster. IDLE is only entered at a frame wrap or by Reset, so h/v are
  // already 0 there and RUN starts on pixel (0,0) in its first cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      h <= '0;
      v <= '0;
    end else if (active) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Pattern model advances per accepted pixel only, so it carries over
  // blanking, frame boundaries and IDLE gaps.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      band_cnt <= '0;
      colour   <= 1'b0;
    end else if (rdy) begin
      if (band_cnt == BAND_LAST) begin
        band_cnt <= '0;
        colour   <= ~colour;
      end else begin
        band_cnt <= band_cnt + 1'b1;
      end
    end
  end

  // Frame and error statistics; a mismatch on the last frame cycle is
  // counted alongside the frame increment.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      FrameCount <= '0;
      ErrorCount <= '0;
      Error      <= 1'b0;
    end else begin
      if (last_cyc) FrameCount <= FrameCount + 1'b1;
      if (mismatch && (ErrorCount != 16'hFFFF)) ErrorCount <= ErrorCount + 1'b1;
      if (mismatch) Error <= 1'b1;
    end
  end

`ifdef CHECKER_FIRST_ERROR_LOG_EN
  // Capture only while Error is still clear: that is the first mismatch.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      FirstErrRow   <= '0;
      FirstErrCol   <= '0;
      FirstErrPixel <= '0;
    end else if (mismatch && !Error) begin
      FirstErrRow   <= 10'(v);
      FirstErrCol   <= 10'(h);
      FirstErrPixel <= vid.video;
    end
  end
`else
  assign FirstErrRow   = '0;
  assign FirstErrCol   = '0;
  assign FirstErrPixel = '0;
`endif

endmodule

// File: tb/tb_video_pattern_checker.sv
module tb_video_pattern_checker;
  localparam int HA = 32;
  localparam int HT = 33;
  localparam int VA = 16;
  localparam int VT = 17;
  localparam int BD = 5;
  localparam int F  = HT * VT;      // cycles per frame
  localparam int PF = HA * VA;      // accepted pixels per frame

  localparam logic [23:0] TURQ = 24'h1ABC9C;
  localparam logic [23:0] CARR = 24'hE67E22;
  localparam logic [23:0] SUNF = 24'hF1C40F;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        FrameDone;
  logic [7:0]  FrameCount;
  logic [15:0] ErrorCount;
  logic        Error;
  logic [9:0]  FirstErrRow;
  logic [9:0]  FirstErrCol;
  logic [23:0] FirstErrPixel;

  video_pattern_checker_if vif ();

  video_pattern_checker #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .BAND(BD)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .vid(vif.slave),
    .FrameDone(FrameDone), .FrameCount(FrameCount), .ErrorCount(ErrorCount),
    .Error(Error), .FirstErrRow(FirstErrRow), .FirstErrCol(FirstErrCol),
    .FirstErrPixel(FirstErrPixel)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;             // 0 ideal, 1 one black pixel, 2 stuck SUNFLOWER
  int bad_idx = 0;
  int idx   = 0;             // accepted pixels since reset (source side)
  int acc   = 0;             // accepted pixels, free running
  int k, base;
  int exp_q[$];              // scoreboard of expected FrameDone cycles

  // Ideal pattern from the pixel ordinal: band = i/BD, odd bands are CARROT.
  function automatic logic [23:0] gen(int i);
    return (((i / BD) % 2) == 1) ? CARR : TURQ;
  endfunction

  // Pattern source: presents the pixel for the next accepting edge.
  always @(negedge Clock) begin
    if (Reset) begin
      idx = 0;
      vif.video = gen(0);
    end else if (vif.VideoReady) begin
      case (mode)
        1:       vif.video = (idx == bad_idx) ? 24'h000000 : gen(idx);
        2:       vif.video = SUNF;
        default: vif.video = gen(idx);
      endcase
      idx++;
      acc++;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock; FrameDone is scored against the expected-cycle queue.
  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
    if (FrameDone === 1'b1) begin
      if (exp_q.size() == 0) chk("frame_done_spurious", cyc, 0);
      else                   chk("frame_done_cycle", cyc, exp_q.pop_front());
    end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, 32'(vif.VideoReady), 0);
    chk({tag, "_framedone"}, 32'(FrameDone), 0);
    chk({tag, "_framecount"}, 32'(FrameCount), 0);
    chk({tag, "_errcount"}, 32'(ErrorCount), 0);
    chk({tag, "_error"}, 32'(Error), 0);
    chk({tag, "_firsterr"}, 32'(FirstErrRow) | 32'(FirstErrCol) | 32'(FirstErrPixel), 0);
  endtask

  initial begin
    Reset = 1'b1;
    Enable = 1'b0;
    vif.video = '0;

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    Reset = 1'b0;
    step();
    chk("idle_ready", 32'(vif.VideoReady), 0);

    // Four ideal frames back to back, then Enable drops in frame 5
    base = acc;
    Enable = 1'b1;
    k = cyc;
    for (int i = 1; i <= 4; i++) exp_q.push_back(k + i * F);
    step();
    chk("first_ready", 32'(vif.VideoReady), 1);
    wait_until(k + 1 + HT);
    chk("line0_pixels", 32'(acc - base), HA);
    chk("line1_ready", 32'(vif.VideoReady), 1);
    wait_until(k + 1 + VA * HT);
    chk("blank_ready", 32'(vif.VideoReady), 0);
    wait_until(k + F + 1);
    chk("frame1_count", 32'(FrameCount), 1);
    chk("frame1_pixels", 32'(acc - base), PF);
    wait_until(k + 4 * F + 1);
    chk("frame4_count", 32'(FrameCount), 4);
    chk("frame4_pixels", 32'(acc - base), 4 * PF);
    chk("frame4_errs", 32'(ErrorCount), 0);
    wait_until(k + 4 * F + 1 + 5 * HT + 3);
    Enable = 1'b0;
    exp_q.push_back(k + 5 * F);
    wait_until(k + 4 * F + 1 + 10 * HT);
    chk("stop_ready_continues", 32'(vif.VideoReady), 1);
    wait_until(k + 5 * F + 1);
    chk("stop_framecount", 32'(FrameCount), 5);
    chk("stop_pixels", 32'(acc - base), 5 * PF);
    chk("stop_errs", 32'(ErrorCount), 0);
    repeat (4) step();
    chk("idle_after_stop", 32'(vif.VideoReady), 0);

    // Single black pixel at row 2 col 5, with a STOP->RUN bounce mid-frame
    Reset = 1'b1;
    exp_q.delete();
    repeat (2) step();
    Reset = 1'b0;
    step();
    mode = 1;
    bad_idx = 2 * HA + 5;
    Enable = 1'b1;
    k = cyc;
    exp_q.push_back(k + F);
    step();
    Enable = 1'b0;
    repeat (5) step();
    Enable = 1'b1;
    repeat (5) step();
    Enable = 1'b0;
    wait_until(k + F + 1);
    chk("err1_count", 32'(ErrorCount), 1);
    chk("err1_flag", 32'(Error), 1);
    chk("err1_frames", 32'(FrameCount), 1);
    chk("err1_idle", 32'(vif.VideoReady), 0);
`ifdef CHECKER_FIRST_ERROR_LOG_EN
    chk("err1_row", 32'(FirstErrRow), 2);
    chk("err1_col", 32'(FirstErrCol), 5);
    chk("err1_pixel", 32'(FirstErrPixel), 0);
`else
    chk("err1_row", 32'(FirstErrRow), 0);
    chk("err1_col", 32'(FirstErrCol), 0);
    chk("err1_pixel", 32'(FirstErrPixel), 0);
`endif

    // Reset mid-frame at row 3 col 4 while running; restart needs Enable
    mode = 0;
    Enable = 1'b1;
    k = cyc;
    exp_q.push_back(k + F);
    wait_until(k + 1 + 3 * HT + 4);
    Reset = 1'b1;
    exp_q.delete();
    step();
    chk_all_zero("midreset");
    Enable = 1'b0;
    step();
    Reset = 1'b0;
    repeat (2) step();
    chk("post_reset_idle", 32'(vif.VideoReady), 0);
    Enable = 1'b1;
    k = cyc;
    exp_q.push_back(k + F);
    step();
    chk("restart_ready", 32'(vif.VideoReady), 1);
    repeat (HT) step();
    chk("restart_turquoise_errs", 32'(ErrorCount), 0);
    Enable = 1'b0;
    wait_until(k + F + 1);
    chk("restart_frames", 32'(FrameCount), 1);
    chk("restart_errs", 32'(ErrorCount), 0);

    // Stuck source: enough accepted pixels to saturate ErrorCount
    mode = 2;
    base = acc;
    Enable = 1'b1;
    k = cyc;
    for (int i = 1; i <= 129; i++) exp_q.push_back(k + i * F);
    wait_until(k + 128 * F + 10);
    Enable = 1'b0;
    wait_until(k + 129 * F + 1);
    chk("sat_pixels", 32'(acc - base), 129 * PF);
    chk("sat_errcount", 32'(ErrorCount), 65535);
    chk("sat_error", 32'(Error), 1);
    chk("sat_frames", 32'(FrameCount), 130);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_pattern_checker.md
VIDEO_PATTERN_CHECKER -- requirements
Module: video_pattern_checker

Interface
REQ-001 Parameters SHALL be: H_ACTIVE, default 800, active pixels per line; H_TOTAL, default 1056, cycles per line; V_ACTIVE, default 600, active lines; V_TOTAL, default 628, lines per frame; BAND, default 80, pixels per colour band.
REQ-002 Clock  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Enable  input  1  request to run; level-sensitive.
REQ-005 video  input  24  pixel from the pattern source, {R,G,B} 8 bits each, valid whenever VideoReady is high.
REQ-006 VideoReady  output  1  consume strobe to the pattern source; one pixel accepted per high cycle.
REQ-007 FrameDone  output  1  one-cycle pulse on the last cycle of each frame.
REQ-008 FrameCount  output  8  completed frames, wraps 255->0.
REQ-009 ErrorCount  output  16  mismatched pixels, saturates at 65535.
REQ-010 Error  output  1  sticky; set on the first mismatch.
REQ-011 FirstErrRow  output  10  row of the first mismatch (see REQ-027).
REQ-012 FirstErrCol  output  10  column of the first mismatch.
REQ-013 FirstErrPixel  output  24  received pixel at the first mismatch.

Function
REQ-014 Raster counters SHALL be h (0..H_TOTAL-1) and v (0..V_TOTAL-1); h increments every cycle while not IDLE; on wrap h=0 and v increments; v wraps to 0 after V_TOTAL-1.
REQ-015 VideoReady SHALL be high only when state is not IDLE, h<H_ACTIVE, and v<V_ACTIVE; it SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-016 FSM states SHALL be IDLE, RUN, and STOP.
REQ-017 In IDLE with Enable=1, the FSM SHALL move to RUN with h=v=0 on the next cycle; the first VideoReady SHALL occur in that cycle.
REQ-018 In RUN with Enable=0, the FSM SHALL move to STOP; the current frame SHALL complete unchanged.
REQ-019 In STOP with Enable=1, the FSM SHALL return to RUN without a raster discontinuity.
REQ-020 On the last frame cycle (h=H_TOTAL-1, v=V_TOTAL-1), FrameDone SHALL pulse and FrameCount SHALL increment; STOP SHALL then go to IDLE and RUN SHALL stay in RUN.
REQ-021 The expected-pixel model SHALL use a band counter (0..BAND-1) and a colour bit, both advancing only on cycles where VideoReady is high.
REQ-022 When the band counter wraps BAND-1->0, the colour bit SHALL toggle.
REQ-023 The expected pixel SHALL be TURQUOISE {26,188,156} when the colour bit is 0 and CARROT {230,126,34} when it is 1.
REQ-024 The model state SHALL persist across lines, frames, and IDLE periods; only Reset clears it.
REQ-025 On each VideoReady cycle with video != expected, ErrorCount SHALL increment, holding at 65535, and Error SHALL set.
REQ-026 Simultaneous mismatch and FrameDone SHALL both take effect in the same cycle.

Reset
REQ-027 Reset SHALL force: state IDLE, h=v=0, band counter 0, colour bit 0, VideoReady=0, FrameDone=0, FrameCount=0, ErrorCount=0, Error=0, FirstErr* = 0.
REQ-028 Reset asserted mid-frame SHALL take priority over all other updates; the next frame SHALL restart from h=v=0 only after Enable is seen in IDLE.

Configuration
REQ-029 With macro CHECKER_FIRST_ERROR_LOG_EN defined, the first mismatch after Reset SHALL latch v into FirstErrRow, h into FirstErrCol, and video into FirstErrPixel; these SHALL hold until Reset.
REQ-030 Without CHECKER_FIRST_ERROR_LOG_EN, the FirstErr* ports SHALL exist but be constant 0, and no capture registers SHALL be built.

Verification
REQ-031 Reset, Enable=1, ideal source for one frame -> VideoReady high 800 cycles per line on lines 0..599; FrameDone pulse at cycle 663,167 after start; FrameCount=1; ErrorCount=0.
REQ-032 Source output forced to {0,0,0} at column 5, row 2, with the macro defined -> ErrorCount=1; Error=1; FirstErrRow=2; FirstErrCol=5; FirstErrPixel=0.
REQ-033 Enable dropped at row 100 of frame 0 -> VideoReady continues through row 599; FrameDone pulses; FSM goes to IDLE; VideoReady=0 afterwards.
REQ-034 Source stuck at SUNFLOWER for 70,000 accepted pixels -> ErrorCount=65535 with no wrap; Error=1.
REQ-035 Reset asserted at row 300, column 400, then Enable=1 -> all outputs 0 during Reset; next VideoReady at h=v=0; first expected pixel is TURQUOISE.
REQ-036 Four consecutive frames with an ideal source -> FrameCount=4; 480,000 pixels per frame accepted; model colour sequence continuous across frame boundaries.
